ahb_default_slave: RTL and testbench



---
 rtl/ahb_default_slave_pkg.sv | 27 ++
 rtl/ahb_defslv_err_log.sv | 78 +++++++
 rtl/ahb_default_slave.sv | 118 +++++++++++
 tb/tb_ahb_default_slave.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_default_slave_pkg.sv
// rtl/ahb_default_slave_pkg.sv - shared AHB types, default widths and default-slave FSM states
package ahb_default_slave_pkg;

    localparam int AHB_ADDR_WIDTH_DFLT = 32;
    localparam int AHB_DATA_WIDTH_DFLT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_type;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } defslv_state_t;

endpackage

// File: rtl/ahb_defslv_err_log.sv
// rtl/ahb_defslv_err_log.sv - first-fault capture, saturating error counter and sticky irq
//
// Ports:
//   hclk, hreset   bus clock, synchronous active-high reset
//   acc_i          accepted NONSEQ/SEQ transfer to the default slave
//   haddr_i        address-phase address of that transfer
//   hwrite_i       address-phase direction of that transfer
//   err_clr_i      clears all logged state; a coincident acc_i still logs
//   err_irq_o      sticky error flag
//   err_addr_o     address of the first error since clear
//   err_write_o    direction of the first error since clear
//   err_count_o    saturating count of errors
module ahb_defslv_err_log #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  acc_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic                  hwrite_i,
    input  logic                  err_clr_i,
    output logic                  err_irq_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic                  err_write_o,
    output logic [CNT_WIDTH-1:0]  err_count_o
);

    logic                  irq_q,   irq_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  write_q, write_d;
    logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;

    // Clear is applied first so that a coincident error lands on a
    // freshly cleared log: count 1, irq set, address captured.
    always_comb begin
        irq_d   = irq_q;
        addr_d  = addr_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        if (err_clr_i) begin
            irq_d   = 1'b0;
            addr_d  = '0;
            write_d = 1'b0;
            cnt_d   = '0;
        end
        if (acc_i) begin
            if (cnt_d != '1) begin
                cnt_d = cnt_d + CNT_WIDTH'(1);
            end
            if (!irq_d) begin
                addr_d  = haddr_i;
                write_d = hwrite_i;
            end
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            irq_q   <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            irq_q   <= irq_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
        end
    end

    assign err_irq_o   = irq_q;
    assign err_addr_o  = addr_q;
    assign err_write_o = write_q;
    assign err_count_o = cnt_q;

endmodule

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - AHB default slave: two-cycle ERROR for unmapped transfers, optional fault log
//
// Build option: AHB_DEFSLV_LOG_EN instantiates ahb_defslv_err_log; without it
// the err_* outputs are tied to 0 and err_clr is ignored.
//
// Ports:
//   hclk, hreset   bus clock, synchronous active-high reset
//   hsel           default-slave select from the address decoder
//   haddr, htrans, hwrite, hready   AHB address-phase inputs
//   hreadyout, hresp, hrdata        AHB slave response (hrdata always 0)
//   err_clr        clear logged error state
//   err_irq, err_addr, err_write, err_count   error log outputs
module ahb_default_slave
    import ahb_default_slave_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = AHB_ADDR_WIDTH_DFLT,
    parameter int AHB_DATA_WIDTH = AHB_DATA_WIDTH_DFLT,
    parameter int ERR_CNT_WIDTH  = 16
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      hsel,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    input  htrans_type                htrans,
    input  logic                      hwrite,
    input  logic                      hready,
    output logic                      hreadyout,
    output hresp_type                 hresp,
    output logic [AHB_DATA_WIDTH-1:0] hrdata,
    input  logic                      err_clr,
    output logic                      err_irq,
    output logic [AHB_ADDR_WIDTH-1:0] err_addr,
    output logic                      err_write,
    output logic [ERR_CNT_WIDTH-1:0]  err_count
);

    defslv_state_t state_q;
    logic          hreadyout_q;
    hresp_type     hresp_q;
    logic          acc;

    assign acc = hsel & hready & ((htrans == NONSEQ) | (htrans == SEQ));

    // Outputs are registered alongside the state so they change only on
    // the edge that enters the state they belong to.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= OKAY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        state_q     <= ST_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= ERROR;
                    end
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= ERROR;
                end
                ST_ERR2: begin
                    // A new error sampled in the completing cycle restarts
                    // the response without an OKAY gap.
                    if (acc) begin
                        state_q     <= ST_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= ERROR;
                    end else begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= OKAY;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= OKAY;
                end
            endcase
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign hrdata    = '0;

`ifdef AHB_DEFSLV_LOG_EN
    ahb_defslv_err_log #(
        .ADDR_WIDTH (AHB_ADDR_WIDTH),
        .CNT_WIDTH  (ERR_CNT_WIDTH)
    ) u_err_log (
        .hclk        (hclk),
        .hreset      (hreset),
        .acc_i       (acc),
        .haddr_i     (haddr),
        .hwrite_i    (hwrite),
        .err_clr_i   (err_clr),
        .err_irq_o   (err_irq),
        .err_addr_o  (err_addr),
        .err_write_o (err_write),
        .err_count_o (err_count)
    );
`else
    // Inputs that only feed the log are sunk here in the non-logging build.
    logic unused_log_inputs;
    assign unused_log_inputs = ^{err_clr, haddr, hwrite};

    assign err_irq   = 1'b0;
    assign err_addr  = '0;
    assign err_write = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_ahb_default_slave.sv
// tb/tb_ahb_default_slave.sv - randomized self-checking bench for ahb_default_slave
module tb_ahb_default_slave;
    import ahb_default_slave_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;
`ifdef AHB_DEFSLV_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic          hclk = 1'b0;
    logic          hreset;
    logic          hsel;
    logic [AW-1:0] haddr;
    htrans_type    htrans;
    logic          hwrite;
    logic          hready;
    logic          hreadyout;
    hresp_type     hresp;
    logic [DW-1:0] hrdata;
    logic          err_clr;
    logic          err_irq;
    logic [AW-1:0] err_addr;
    logic          err_write;
    logic [CW-1:0] err_count;

    always #5 hclk = ~hclk;

    ahb_default_slave #(
        .AHB_ADDR_WIDTH (AW),
        .AHB_DATA_WIDTH (DW),
        .ERR_CNT_WIDTH  (CW)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .err_clr   (err_clr),
        .err_irq   (err_irq),
        .err_addr  (err_addr),
        .err_write (err_write),
        .err_count (err_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the response is a function of how many edges ago
    // the last accepted error transfer was taken; the log is plain counters.
    int          cyc      = 0;
    int          last_acc = -10;
    int          m_cnt    = 0;
    bit          m_irq    = 1'b0;
    logic [AW-1:0] m_addr = '0;
    bit          m_write  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit in_err1();
        return (cyc - last_acc) == 0;
    endfunction

    task automatic drive(input bit sel, input htrans_type tr, input bit rdy,
                         input logic [AW-1:0] addr, input bit wr, input bit clr);
        hsel    = sel;
        htrans  = tr;
        hready  = rdy;
        haddr   = addr;
        hwrite  = wr;
        err_clr = clr;
    endtask

    task automatic step();
        bit a;
        int ph;
        a = !hreset && hsel && hready && (htrans == NONSEQ || htrans == SEQ) && !in_err1();
        @(posedge hclk);
        cyc++;
        if (hreset) begin
            last_acc = cyc - 10;
            m_cnt = 0; m_irq = 1'b0; m_addr = '0; m_write = 1'b0;
        end else begin
            if (err_clr) begin
                m_cnt = 0; m_irq = 1'b0; m_addr = '0; m_write = 1'b0;
            end
            if (a) begin
                last_acc = cyc;
                if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
                if (!m_irq) begin
                    m_addr  = haddr;
                    m_write = hwrite;
                end
                m_irq = 1'b1;
            end
        end
        #1;
        ph = cyc - last_acc;
        check("hreadyout", 64'(hreadyout), 64'(ph != 0));
        check("hresp", 64'(hresp), (ph == 0 || ph == 1) ? 64'(ERROR) : 64'(OKAY));
        check("hrdata", 64'(hrdata), 64'd0);
        check("err_irq", 64'(err_irq), LOG ? 64'(m_irq) : 64'd0);
        check("err_addr", 64'(err_addr), LOG ? 64'(m_addr) : 64'd0);
        check("err_write", 64'(err_write), LOG ? 64'(m_write) : 64'd0);
        check("err_count", 64'(err_count), LOG ? 64'(m_cnt) : 64'd0);
    endtask

    initial begin
        hreset = 1'b1;
        drive(0, IDLE, 1, '0, 0, 0);
        step(); step();
        hreset = 1'b0;

        // IDLE/BUSY while selected: zero-wait OKAY
        drive(1, IDLE, 1, 32'h10, 0, 0); step();
        drive(1, BUSY, 1, 32'h14, 0, 0); step();
        drive(1, IDLE, 1, 32'h18, 0, 0); step();

        // Single NONSEQ write
        drive(1, NONSEQ, 1, 32'hDEAD_0000, 1, 0); step();
        drive(1, IDLE, 0, '0, 0, 0);              step();
        drive(0, IDLE, 1, '0, 0, 0);              step(); step();

        // Back-to-back: second error presented in the ERR2 cycle
        drive(1, NONSEQ, 1, 32'h100, 0, 0); step();
        drive(1, IDLE, 0, '0, 0, 0);        step();
        drive(1, SEQ, 1, 32'h104, 1, 0);    step();
        drive(1, IDLE, 0, '0, 0, 0);        step();
        drive(0, IDLE, 1, '0, 0, 0);        step(); step();

        // hready low holds off sampling
        drive(1, NONSEQ, 0, 32'h300, 1, 0); step(); step();
        drive(1, NONSEQ, 1, 32'h300, 1, 0); step();
        drive(0, IDLE, 0, '0, 0, 0);        step();
        drive(0, IDLE, 1, '0, 0, 0);        step(); step();

        // Clear coincident with a new error
        drive(1, NONSEQ, 1, 32'h200, 0, 1); step();
        drive(0, IDLE, 0, '0, 0, 0);        step();
        drive(0, IDLE, 1, '0, 0, 0);        step(); step();

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            drive(1, NONSEQ, 1, 32'h400 + 32'(i * 4), 0, 0); step();
            drive(1, IDLE, 0, '0, 0, 0);                     step();
        end
        drive(0, IDLE, 1, '0, 0, 0); step(); step();

        // Reset during ERR1
        drive(1, NONSEQ, 1, 32'h500, 1, 0); step();
        drive(0, IDLE, 0, '0, 0, 0);
        hreset = 1'b1;                      step();
        hreset = 1'b0;
        drive(0, IDLE, 1, '0, 0, 0);        step(); step();

        // Randomized traffic; hready follows the slave's own wait state
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, htrans_type'($urandom_range(0, 3)),
                  in_err1() ? 1'b0 : ($urandom_range(0, 4) != 0),
                  $urandom(), $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
            hreset = ($urandom_range(0, 49) == 0);
            step();
        end
        hreset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
